clock_psc_mc: RTL and testbench
===============================

# clock_psc_mc

Multi-channel, parametrised prescaler that generates divided enables and waveforms from the single system clock. Each channel has its own limit, duty, and mode (toggle, single-cycle pulse, PWM). Limit and duty are shadowed so that on-the-fly changes take effect only at a period boundary. The block sits beside the core clock and feeds peripheral timing: baud ticks, LED/PWM drivers, and slow-domain strobes. It replaces the single 8-bit toggle prescaler.

## Interface
Parameters:
- N_CH, 4, number of independent channels (1..16)
- CNT_W, 16, width of counter, limit and duty (2..32)

Ports:
- clk  input  1  system clock; the only clock
- rst  input  1  asynchronous, active-low reset
- en  input  N_CH  per-channel enable
- mode  input  N_CH x 2  per-channel mode: 00 TOGGLE, 01 PULSE, 10 PWM, 11 reserved
- lim  input  N_CH x CNT_W  per-channel terminal count; period is lim+1 cycles
- duty  input  N_CH x CNT_W  PWM high-time in cycles
- sync_clr  input  1  restarts every channel phase simultaneously
- out  output  N_CH  registered channel waveform
- tick  output  N_CH  registered one-cycle strobe at each period wrap

## Operation
Per-channel state:
- ctr[CNT_W], counts 0..lim_sh
- lim_sh, duty_sh, mode_sh: shadow registers
- tgl: toggle flop

Shadow loading:
- Shadows load from the inputs on reset release, on every wrap, on sync_clr, and on every cycle while en=0.
- A mid-period write to lim, duty or mode therefore never shortens or extends the current period.

Counting and wrap:
- While en=1, a wrap occurs on an edge where ctr==lim_sh.
- At a wrap edge: ctr←0, tick←1, tgl←~tgl, shadows reload.
- At any other enabled edge: ctr←ctr+1, tick←0.
- Counter arithmetic is unsigned CNT_W; ctr never exceeds lim_sh, so there is no overflow path.

out per mode_sh (registered, computed from next-state values):
- TOGGLE: out = tgl. Period is 2·(lim+1) cycles, 50 % duty.
- PULSE: out = tick.
- PWM: out = (ctr_next < duty_sh_next).
  - duty=0 gives constant 0.
  - duty>lim gives constant 1.
- reserved (11): out=0. Counter and tick still run.

lim=0:
- tick is high every cycle; TOGGLE gives clk/2.
- There is no combinational clock bypass. out is always a flop output, so the block is glitch-free and usable as an enable.

en=0:
- ctr, tgl, tick and out are forced to 0 at the next edge.
- Shadows track the inputs.

sync_clr=1 (priority over wrap and en):
- All channels: ctr←0, tgl←0, tick←0, out←0, shadows reload.

Reset (rst=0, asynchronous):
- ctr=0, tgl=0, tick=0, out=0.
- Shadows are 0, then reload on the first edge.
- Reset mid-period discards the phase with no partial tick.

## Timing
- Latency: with ctr=0 and en sampled high at edge E1, the first tick is high after edge E(lim+1), for exactly one cycle. Subsequent ticks follow every lim+1 edges.
- TOGGLE out changes on the same edge as tick.
- PWM: out is high for cycles 0..duty-1 of each period, aligned with ctr.
- en deassertion: tick and out are 0 after the next edge.
- Re-enable restarts from ctr=0.
- sync_clr asserted at edge S: every channel behaves as freshly enabled from edge S+1. Channels with equal lim produce coincident ticks thereafter.
- Channels are fully independent. There is no cross-channel combinational path.

## Structure
Package clock_psc_pkg holds:
- psc_mode_e (TOGGLE, PULSE, PWM, RSVD)
- PSC_MAX_CH constant
- packed per-channel config struct {mode, lim, duty}, parametrised through CNT_W in the top module

One sub-module, clock_psc_ch, implements a single channel (counter, shadows, tgl, output mux). The top generates N_CH instances and broadcasts sync_clr to all of them.

## Test plan
- Reset then release:
  - Stimulus: ch0 TOGGLE with lim=3, en=1.
  - Required: tick high after edges 4, 8, 12; out toggles at each tick, giving period 8; all outputs 0 during rst=0.
- lim=0:
  - Stimulus: ch1 TOGGLE and PULSE.
  - Required: tick constantly 1 from edge 1; TOGGLE out alternates every cycle; out is never a copy of clk.
- Shadowing:
  - Stimulus: ch0 lim=9, change lim to 2 when ctr=4.
  - Required: current period still wraps at ctr=9; following periods are 3 cycles.
- PWM:
  - Stimulus: lim=9 with duty=3, then duty=0, then duty=12.
  - Required: out high 3 of 10 cycles, then constant 0, then constant 1; duty changes apply only at the wrap.
- sync_clr alignment:
  - Stimulus: ch0 and ch1 both lim=4, ch1 enabled 2 cycles later, then pulse sync_clr.
  - Required: ticks coincide from 5 edges after the sync_clr edge.
- Async reset mid-period:
  - Stimulus: assert rst=0 between edges while ctr=2 on ch2 (lim=7).
  - Required: outputs drop to 0 immediately without waiting for an edge; no tick is emitted; counting restarts from 0 after release.

Source files
------------

// File: rtl/clock_psc_pkg.sv
// clock_psc_pkg: shared mode encoding and limits for the multi-channel prescaler.
package clock_psc_pkg;
  localparam int PSC_MAX_CH = 16;
  localparam int PSC_MAX_W = 32;
  typedef enum logic [1:0] {
    TOGGLE = 2'b00,
    PULSE  = 2'b01,
    PWM    = 2'b10,
    RSVD   = 2'b11
  } psc_mode_e;
endpackage

// File: rtl/clock_psc_ch.sv
// clock_psc_ch: one prescaler channel with shadowed limit/duty/mode and registered outputs.
module clock_psc_ch
  import clock_psc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_clr,
  input  psc_mode_e        mode,
  input  logic [CNT_W-1:0] lim,
  input  logic [CNT_W-1:0] duty,
  output logic             out,
  output logic             tick
);
  logic [CNT_W-1:0] ctr, lim_sh, duty_sh, ctr_n, lim_n, duty_n;
  psc_mode_e mode_sh, mode_n;
  logic tgl, tgl_n, tick_n, out_n, fresh, run, wrap, load;
  // fresh marks the first edge after reset, when the zeroed shadows are not yet valid
  always_comb begin
    run = en & ~sync_clr;
    wrap = run & (ctr == (fresh ? lim : lim_sh));
    load = fresh | wrap | ~run;
    lim_n = load ? lim : lim_sh;
    duty_n = load ? duty : duty_sh;
    mode_n = load ? mode : mode_sh;
    ctr_n = (!run || wrap) ? '0 : ctr + CNT_W'(1);
    tick_n = wrap;
    tgl_n = run & (tgl ^ wrap);
    out_n = run & (mode_n == TOGGLE ? tgl_n :
                   mode_n == PULSE  ? tick_n :
                   mode_n == PWM    ? (ctr_n < duty_n) : 1'b0);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctr <= '0;
      lim_sh <= '0;
      duty_sh <= '0;
      mode_sh <= TOGGLE;
      tgl <= 1'b0;
      tick <= 1'b0;
      out <= 1'b0;
      fresh <= 1'b1;
    end else begin
      ctr <= ctr_n;
      lim_sh <= lim_n;
      duty_sh <= duty_n;
      mode_sh <= mode_n;
      tgl <= tgl_n;
      tick <= tick_n;
      out <= out_n;
      fresh <= 1'b0;
    end
  end
endmodule

// File: rtl/clock_psc_mc.sv
// clock_psc_mc: N_CH independent prescaler channels sharing one clock and a common phase clear.
module clock_psc_mc
  import clock_psc_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_CH-1:0]             en,
  input  logic [N_CH-1:0][1:0]        mode,
  input  logic [N_CH-1:0][CNT_W-1:0]  lim,
  input  logic [N_CH-1:0][CNT_W-1:0]  duty,
  input  logic                        sync_clr,
  output logic [N_CH-1:0]             out,
  output logic [N_CH-1:0]             tick
);
  typedef struct packed {
    psc_mode_e        mode;
    logic [CNT_W-1:0] lim;
    logic [CNT_W-1:0] duty;
  } cfg_t;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    cfg_t cfg;
    assign cfg = '{mode: psc_mode_e'(mode[i]), lim: lim[i], duty: duty[i]};
    clock_psc_ch #(.CNT_W(CNT_W)) u_ch (
      .clk(clk),
      .rst(rst),
      .en(en[i]),
      .sync_clr(sync_clr),
      .mode(cfg.mode),
      .lim(cfg.lim),
      .duty(cfg.duty),
      .out(out[i]),
      .tick(tick[i])
    );
  end
endmodule

// File: tb/tb_clock_psc_mc.sv
// tb_clock_psc_mc: directed vectors and hand-checked sequences for the multi-channel prescaler.
module tb_clock_psc_mc;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] en;
  logic [3:0][1:0] mode;
  logic [3:0][15:0] lim, duty;
  logic sync_clr;
  logic [3:0] out, tick;
  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] en;
    logic       sclr;
    logic [3:0] tick;
    logic [3:0] out;
  } vec_t;
  vec_t tbl [12];

  clock_psc_mc #(.N_CH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .lim(lim), .duty(duty),
    .sync_clr(sync_clr), .out(out), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_cfg();
    en = 4'b0000;
    sync_clr = 1'b0;
    mode = '0;
    lim = '0;
    duty = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic et, eo, e0, e1;
    tbl = '{
      '{4'b1011, 1'b0, 4'b1010, 4'b1010},
      '{4'b1011, 1'b0, 4'b1010, 4'b1000},
      '{4'b1011, 1'b0, 4'b1010, 4'b1010},
      '{4'b1011, 1'b0, 4'b1011, 4'b1001},
      '{4'b1011, 1'b0, 4'b1010, 4'b1011},
      '{4'b1011, 1'b0, 4'b1010, 4'b1001},
      '{4'b1011, 1'b0, 4'b1010, 4'b1011},
      '{4'b1011, 1'b0, 4'b1011, 4'b1000},
      '{4'b1011, 1'b0, 4'b1010, 4'b1010},
      '{4'b1011, 1'b0, 4'b1010, 4'b1000},
      '{4'b1011, 1'b0, 4'b1010, 4'b1010},
      '{4'b1011, 1'b0, 4'b1011, 4'b1001}
    };
    rst = 1'b0;
    idle_cfg();
    step();
    step();
    check("rst_tick", tick, 4'b0000);
    check("rst_out", out, 4'b0000);
    // ch0 TOGGLE lim=3, ch1 TOGGLE lim=0, ch3 PULSE lim=0, enabled while still in reset
    mode[0] = 2'b00; lim[0] = 16'd3;
    mode[1] = 2'b00; lim[1] = 16'd0;
    mode[3] = 2'b01; lim[3] = 16'd0;
    en = 4'b1011;
    step();
    check("rst_en_tick", tick, 4'b0000);
    check("rst_en_out", out, 4'b0000);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      en = tbl[i].en;
      sync_clr = tbl[i].sclr;
      step();
      check($sformatf("A_tick[%0d]", i + 1), tick, tbl[i].tick);
      check($sformatf("A_out[%0d]", i + 1), out, tbl[i].out);
      #5;
      check($sformatf("A_out_lowclk[%0d]", i + 1), out, tbl[i].out);
    end

    // shadowing: ch0 PULSE lim=9, lim changed to 2 when ctr=4
    idle_cfg();
    mode[0] = 2'b01; lim[0] = 16'd9;
    step();
    check("dis_tick", tick, 4'b0000);
    check("dis_out", out, 4'b0000);
    en = 4'b0001;
    for (int k = 1; k <= 19; k++) begin
      step();
      et = (k == 10) || (k == 13) || (k == 16) || (k == 19);
      check($sformatf("B_tick[%0d]", k), tick, {3'b000, et});
      check($sformatf("B_out[%0d]", k), out, {3'b000, et});
      if (k == 4) lim[0] = 16'd2;
    end

    // PWM on ch2: lim=9 duty=3, then duty=0 mid-period, then duty=12 mid-period
    idle_cfg();
    mode[2] = 2'b10; lim[2] = 16'd9; duty[2] = 16'd3;
    step();
    check("C_dis_out", out, 4'b0000);
    en = 4'b0100;
    for (int k = 1; k <= 39; k++) begin
      step();
      eo = (k <= 2) || (k >= 10 && k <= 12) || (k >= 30);
      et = (k == 10) || (k == 20) || (k == 30);
      check($sformatf("C_out[%0d]", k), out, {1'b0, eo, 2'b00});
      check($sformatf("C_tick[%0d]", k), tick, {1'b0, et, 2'b00});
      if (k == 11) duty[2] = 16'd0;
      if (k == 25) duty[2] = 16'd12;
    end

    // sync_clr alignment: ch0, ch1 PULSE lim=4, ch1 starts 2 edges late, clear at edge 9
    idle_cfg();
    mode[0] = 2'b01; lim[0] = 16'd4;
    mode[1] = 2'b01; lim[1] = 16'd4;
    step();
    en = 4'b0001;
    for (int t = 1; t <= 19; t++) begin
      step();
      e0 = (t == 5) || (t == 14) || (t == 19);
      e1 = (t == 7) || (t == 14) || (t == 19);
      check($sformatf("D_tick[%0d]", t), tick, {2'b00, e1, e0});
      check($sformatf("D_out[%0d]", t), out, {2'b00, e1, e0});
      if (t == 2) en = 4'b0011;
      sync_clr = (t == 8);
    end

    // async reset mid-period on ch2: PWM lim=7 duty=5
    idle_cfg();
    mode[2] = 2'b10; lim[2] = 16'd7; duty[2] = 16'd5;
    step();
    en = 4'b0100;
    step();
    step();
    check("E_pre_out", out, 4'b0100);
    #1;
    rst = 1'b0;
    #1;
    check("E_async_out", out, 4'b0000);
    check("E_async_tick", tick, 4'b0000);
    step();
    check("E_hold_out", out, 4'b0000);
    check("E_hold_tick", tick, 4'b0000);
    rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      eo = (k <= 4) || (k == 8);
      et = (k == 8);
      check($sformatf("E_out[%0d]", k), out, {1'b0, eo, 2'b00});
      check($sformatf("E_tick[%0d]", k), tick, {1'b0, et, 2'b00});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
